// File: rtl/sd_cmd_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : sd_cmd_tx_if
// Description : Request/bit-strobe/status bundle between the SD host command
//               logic and the CMD-line transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
interface sd_cmd_tx_if;
    logic        bit_en;       // SD bit-rate strobe
    logic        start;        // command request
    logic [5:0]  cmd_index;    // command index
    logic [31:0] cmd_arg;      // command argument
    logic        cmd_pin_out;  // serial CMD data
    logic        cmd_oe;       // CMD pad output enable
    logic        busy;         // transmitter occupied
    logic        done;         // one-cycle completion pulse

    // Requester side (host command logic)
    modport master (
        output bit_en, start, cmd_index, cmd_arg,
        input  cmd_pin_out, cmd_oe, busy, done
    );

    // Transmitter side
    modport slave (
        input  bit_en, start, cmd_index, cmd_arg,
        output cmd_pin_out, cmd_oe, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/sd_cmd_tx.sv
`default_nettype none
// ============================================================================
// Module      : sd_cmd_tx
// Description : Host-side SD CMD-line transmitter. Serialises a 48-bit
//               command frame (start, dir, index, argument, CRC7, end bit)
//               MSB-first at the bit_en rate, then drives GAP_BITS idle '1'
//               bits with the pad released before accepting a new command.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_cmd_tx #(
    parameter int GAP_BITS = 8          // Ncc idle bits after the end bit, 0..15
) (
    input  logic        clock,
    input  logic        reset,
    sd_cmd_tx_if.slave  cmd_bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FRAME = 3'd1,
        S_CRC   = 3'd2,
        S_ENDB  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    // Last counter value of the gap; unused when there is no gap at all
    localparam logic [5:0] c_gap_last = (GAP_BITS == 0) ? 6'd0 : 6'(GAP_BITS - 1);
    localparam logic [6:0] c_crc_poly = 7'h09;   // x^7 + x^3 + 1

    state_t      r_state, w_state_nxt;
    logic [39:0] r_shift, w_shift_nxt;
    logic [6:0]  r_crc,   w_crc_nxt;
    logic [5:0]  r_cnt,   w_cnt_nxt;
    logic        r_done,  w_done_nxt;

    logic        w_fb;
    logic [6:0]  w_crc_upd;

    // CRC7 step over the bit currently on the line (frame phase only)
    assign w_fb      = r_crc[6] ^ r_shift[39];
    assign w_crc_upd = {r_crc[5:0], 1'b0} ^ (w_fb ? c_crc_poly : 7'h00);

    // State and datapath registers; reset abandons any frame without a done
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_crc   <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_crc   <= w_crc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state, datapath update and line outputs
    always_comb begin
        w_state_nxt         = r_state;
        w_shift_nxt         = r_shift;
        w_crc_nxt           = r_crc;
        w_cnt_nxt           = r_cnt;
        w_done_nxt          = 1'b0;
        cmd_bus.cmd_pin_out = 1'b1;
        cmd_bus.cmd_oe      = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                // A start landing on the done cycle is deliberately dropped;
                // bit_en here is irrelevant, so it cannot eat the start bit.
                if (cmd_bus.start && !r_done) begin
                    w_shift_nxt = {2'b01, cmd_bus.cmd_index, cmd_bus.cmd_arg};
                    w_crc_nxt   = 7'h00;
                    w_cnt_nxt   = 6'd39;
                    w_state_nxt = S_FRAME;
                end
            end
            S_FRAME: begin
                cmd_bus.cmd_oe      = 1'b1;
                cmd_bus.cmd_pin_out = r_shift[39];
                if (cmd_bus.bit_en) begin
                    w_crc_nxt   = w_crc_upd;
                    w_shift_nxt = {r_shift[38:0], 1'b0};
                    if (r_cnt == 6'd0) begin
                        w_cnt_nxt   = 6'd6;
                        w_state_nxt = S_CRC;
                    end else begin
                        w_cnt_nxt = r_cnt - 6'd1;
                    end
                end
            end
            S_CRC: begin
                cmd_bus.cmd_oe      = 1'b1;
                cmd_bus.cmd_pin_out = r_crc[6];
                if (cmd_bus.bit_en) begin
                    w_crc_nxt = {r_crc[5:0], 1'b0};
                    if (r_cnt == 6'd0) begin
                        w_state_nxt = S_ENDB;
                    end else begin
                        w_cnt_nxt = r_cnt - 6'd1;
                    end
                end
            end
            S_ENDB: begin
                cmd_bus.cmd_oe      = 1'b1;
                cmd_bus.cmd_pin_out = 1'b1;
                if (cmd_bus.bit_en) begin
                    if (GAP_BITS == 0) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_nxt   = c_gap_last;
                        w_state_nxt = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (cmd_bus.bit_en) begin
                    if (r_cnt == 6'd0) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt - 6'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign cmd_bus.busy = (r_state != S_IDLE);
    assign cmd_bus.done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sd_cmd_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_sd_cmd_tx
// Description : Directed self-checking bench for sd_cmd_tx. Captures the
//               serial CMD stream and compares it against hand-computed
//               48-bit frames; one instance with an 8-bit gap, one with none.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_cmd_tx;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sd_cmd_tx_if cmd_bus ();
    sd_cmd_tx_if cmd_bus0 ();

    sd_cmd_tx #(.GAP_BITS(8)) dut (
        .clock   (clk),
        .reset   (rst),
        .cmd_bus (cmd_bus)
    );

    sd_cmd_tx #(.GAP_BITS(0)) dut0 (
        .clock   (clk),
        .reset   (rst),
        .cmd_bus (cmd_bus0)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Single comparison point: counts every vector, reports a miscompare
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one command on the GAP_BITS=8 instance with bit_en every 'period'
    // cycles, capture the frame and check timing. inject_bit >= 0 pulses a
    // conflicting start while that bit is on the line.
    task automatic run_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                           input int period, input logic [47:0] exp, input int inject_bit);
        logic [47:0] cap      = '0;
        logic        bit_val  = 1'b1;
        int          nbits    = 0;
        int          oe_cyc   = 0;
        int          busy_cyc = 0;
        int          bad_bits = 0;
        int          hold     = 0;
        int          cyc      = 0;
        int          done_cyc = -1;
        logic        busy_at_done = 1'b1;

        @(posedge clk); #1;
        cmd_bus.start     = 1'b1;
        cmd_bus.cmd_index = idx;
        cmd_bus.cmd_arg   = arg;
        cmd_bus.bit_en    = (period == 1);   // coincident bit_en must not consume the start bit
        @(posedge clk); #1;
        cmd_bus.start     = 1'b0;
        cmd_bus.cmd_index = 6'h2A;           // changes while busy must not matter
        cmd_bus.cmd_arg   = 32'hA5A5_5A5A;

        while (cyc < 60 * period + 10) begin
            cmd_bus.bit_en = ((cyc % period) == (period - 1));
            if (inject_bit >= 0 && nbits == inject_bit) begin
                cmd_bus.start     = 1'b1;
                cmd_bus.cmd_index = 6'h3F;
                cmd_bus.cmd_arg   = 32'hDEAD_BEEF;
            end else begin
                cmd_bus.start = 1'b0;
            end
            @(negedge clk);
            if (cmd_bus.done) begin
                done_cyc     = cyc;
                busy_at_done = cmd_bus.busy;
                break;
            end
            if (cmd_bus.busy) busy_cyc++;
            if (cmd_bus.cmd_oe) begin
                oe_cyc++;
                if (hold == 0) bit_val = cmd_bus.cmd_pin_out;
                else if (cmd_bus.cmd_pin_out !== bit_val) bad_bits++;
                hold++;
                if (cmd_bus.bit_en) begin
                    cap = {cap[46:0], bit_val};
                    if (hold != period) bad_bits++;
                    hold = 0;
                    nbits++;
                end
            end
            cyc++;
            @(posedge clk); #1;
        end
        cmd_bus.start  = 1'b0;
        cmd_bus.bit_en = 1'b0;

        check({tag, "_stream"},    cap,                 exp);
        check({tag, "_nbits"},     nbits,               48);
        check({tag, "_oe_cycles"}, oe_cyc,              48 * period);
        check({tag, "_busy_cyc"},  busy_cyc,            56 * period);
        check({tag, "_done_cyc"},  done_cyc,            56 * period);
        check({tag, "_bit_hold"},  bad_bits,            0);
        check({tag, "_busy_done"}, busy_at_done,        1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_done_width"}, cmd_bus.done,       1'b0);
    endtask

    initial begin
        logic [47:0] cap0;
        int          nb0;
        int          d0;
        int          t0;
        logic        first_pin;
        int          stray;
        int          seen_done;

        rst                = 1'b1;
        cmd_bus.start      = 1'b0;
        cmd_bus.bit_en     = 1'b0;
        cmd_bus.cmd_index  = '0;
        cmd_bus.cmd_arg    = '0;
        cmd_bus0.start     = 1'b0;
        cmd_bus0.bit_en    = 1'b0;
        cmd_bus0.cmd_index = '0;
        cmd_bus0.cmd_arg   = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_pin",  cmd_bus.cmd_pin_out, 1'b1);
        check("rst_oe",   cmd_bus.cmd_oe,      1'b0);
        check("rst_busy", cmd_bus.busy,        1'b0);
        check("rst_done", cmd_bus.done,        1'b0);

        // bit_en while idle does nothing
        @(posedge clk); #1;
        cmd_bus.bit_en = 1'b1;
        stray = 0;
        repeat (5) begin
            @(negedge clk);
            if (cmd_bus.busy || cmd_bus.cmd_oe || cmd_bus.done || !cmd_bus.cmd_pin_out) stray++;
            @(posedge clk); #1;
        end
        cmd_bus.bit_en = 1'b0;
        check("idle_bit_en", stray, 0);

        run_cmd("cmd0",   6'd0,  32'h0000_0000, 1, 48'h40_0000_0000_95, -1);
        run_cmd("cmd8",   6'd8,  32'h0000_01AA, 1, 48'h48_0000_01AA_87, -1);
        run_cmd("cmd17",  6'd17, 32'h0000_0000, 4, 48'h51_0000_0000_55, -1);
        run_cmd("inject", 6'd8,  32'h0000_01AA, 1, 48'h48_0000_01AA_87, 20);
        run_cmd("after",  6'd17, 32'h0000_0000, 1, 48'h51_0000_0000_55, -1);

        // Reset in the middle of CMD55
        @(posedge clk); #1;
        cmd_bus.start     = 1'b1;
        cmd_bus.cmd_index = 6'd55;
        cmd_bus.cmd_arg   = 32'h0;
        cmd_bus.bit_en    = 1'b1;
        @(posedge clk); #1;
        cmd_bus.start = 1'b0;
        repeat (30) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_pin",  cmd_bus.cmd_pin_out, 1'b1);
        check("abort_oe",   cmd_bus.cmd_oe,      1'b0);
        check("abort_busy", cmd_bus.busy,        1'b0);
        check("abort_done", cmd_bus.done,        1'b0);
        stray = 0;
        repeat (40) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (cmd_bus.done || cmd_bus.busy || cmd_bus.cmd_oe) stray++;
        end
        check("abort_quiet", stray, 0);
        cmd_bus.bit_en = 1'b0;
        run_cmd("cmd55", 6'd55, 32'h0000_0000, 1, 48'h77_0000_0000_65, -1);

        // No-gap instance: start held high through done
        @(posedge clk); #1;
        cmd_bus0.start     = 1'b1;
        cmd_bus0.cmd_index = 6'd8;
        cmd_bus0.cmd_arg   = 32'h0000_01AA;
        cmd_bus0.bit_en    = 1'b1;
        cap0 = '0; nb0 = 0; d0 = -1; t0 = -1; first_pin = 1'b1;
        for (int c = 0; c < 200 && t0 < 0; c++) begin
            @(negedge clk);
            if (d0 < 0) begin
                if (cmd_bus0.done) d0 = c;
                else if (cmd_bus0.cmd_oe) begin
                    cap0 = {cap0[46:0], cmd_bus0.cmd_pin_out};
                    nb0++;
                end
            end else if (cmd_bus0.cmd_oe) begin
                t0        = c;
                first_pin = cmd_bus0.cmd_pin_out;
            end
            @(posedge clk); #1;
        end
        cmd_bus0.start = 1'b0;
        check("gap0_stream",   cap0,      48'h48_0000_01AA_87);
        check("gap0_nbits",    nb0,       48);
        check("gap0_done_cyc", d0,        49);
        check("gap0_restart",  t0 - d0,   2);
        check("gap0_startbit", first_pin, 1'b0);

        // Let the second frame finish
        seen_done = 0;
        for (int c = 0; c < 100 && seen_done == 0; c++) begin
            @(negedge clk);
            if (cmd_bus0.done) seen_done = 1;
            @(posedge clk); #1;
        end
        check("gap0_second_done", seen_done, 1);
        cmd_bus0.bit_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
